tt_load_drain_seq: RTL and testbench

- Load-queue drain sequencer sitting directly downstream of the vector memory scoreboard.
- Accepts a drain request (start lqid, entry count) for one load instruction.
- Walks the load queue ring from the start lqid, waits for each entry's returned data, and pushes it to the VRF writeback port.
- Pulses a per-entry commit back to the scoreboard, which decrements that instruction's ref count.

---
 rtl/tt_load_drain_seq_pkg.sv | 28 ++
 rtl/tt_load_drain_seq_if.sv | 28 ++
 rtl/tt_load_drain_seq_sat_counter.sv | 19 +
 rtl/tt_load_drain_seq.sv | 121 ++++++++++++
 tb/tb_tt_load_drain_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_load_drain_seq_pkg.sv
// Shared types for the vector load-queue drain path.
// Ring geometry, drain FSM states and the writeback beat bundle.
package tt_vpu_lq_pkg;

    localparam int LQ_DEPTH = 8;
    localparam int LQID_W   = 3;
    localparam int DATA_W   = 512;

    typedef logic [LQID_W-1:0] lqid_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WB
    } drain_state_e;

    typedef struct packed {
        lqid_t             lqid;
        logic [DATA_W-1:0] data;
        logic              last;
    } lq_wb_t;

    // Ring advance; LQ_DEPTH is a power of two so the add wraps.
    function automatic lqid_t lqid_inc(lqid_t l);
        return l + 1'b1;
    endfunction

endpackage

// File: rtl/tt_load_drain_seq_if.sv
// VRF writeback channel: valid/ready beat carrying lqid, data and last.
// master drives the beat, slave returns ready.
interface tt_load_drain_seq_if;
    import tt_vpu_lq_pkg::*;

    logic              valid;
    logic              ready;
    lqid_t             lqid;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (
        output valid,
        output lqid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  lqid,
        input  data,
        input  last,
        output ready
    );

endinterface

// File: rtl/tt_load_drain_seq_sat_counter.sv
// Saturating event counter: holds at all-ones, clears on reset.
module tt_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tt_load_drain_seq.sv
// Load-queue drain sequencer: walks the LQ ring, forwards data to VRF wb.
// Stall counters built only with TT_LOAD_DRAIN_PERF_EN defined.
module tt_load_drain_seq
    import tt_vpu_lq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_drain_req,
    input  lqid_t               i_drain_ref_count,
    input  lqid_t               i_drain_lqid_start,
    output logic                o_draining,
    input  logic [LQ_DEPTH-1:0] i_lq_data_valid,
    output lqid_t               o_lq_rd_lqid,
    input  logic [DATA_W-1:0]   i_lq_rd_data,
    tt_load_drain_seq_if.master wb,
    output logic                o_lq_commit,
    output lqid_t               o_dest_lqid,
    output logic [31:0]         o_perf_wait_cycles,
    output logic [31:0]         o_perf_bp_cycles
);

    localparam logic [LQID_W:0] FULL_CNT = LQ_DEPTH[LQID_W:0];

    drain_state_e      state;
    lqid_t             ptr;
    logic [LQID_W:0]   remaining;
    lq_wb_t            wb_q;
    logic              wb_valid_q;
    logic              data_rdy;
    logic              last_entry;

    assign data_rdy   = i_lq_data_valid[ptr];
    assign last_entry = (remaining == 'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            remaining   <= '0;
            wb_q        <= '0;
            wb_valid_q  <= 1'b0;
            o_draining  <= 1'b0;
            o_lq_commit <= 1'b0;
            o_dest_lqid <= '0;
        end else begin
            o_lq_commit <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_drain_req) begin
                        ptr        <= i_drain_lqid_start;
                        // ref count of zero means the whole ring
                        remaining  <= (i_drain_ref_count == '0)
                                      ? FULL_CNT
                                      : {1'b0, i_drain_ref_count};
                        o_draining <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (data_rdy) begin
                        wb_q.lqid  <= ptr;
                        wb_q.data  <= i_lq_rd_data;
                        wb_q.last  <= last_entry;
                        wb_valid_q <= 1'b1;
                        state      <= WB;
                    end
                end
                WB: begin
                    if (wb.ready) begin
                        wb_valid_q  <= 1'b0;
                        o_lq_commit <= 1'b1;
                        o_dest_lqid <= ptr;
                        ptr         <= lqid_inc(ptr);
                        remaining   <= remaining - 1'b1;
                        if (last_entry) begin
                            o_draining <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_lq_rd_lqid = ptr;
    assign wb.valid     = wb_valid_q;
    assign wb.lqid      = wb_q.lqid;
    assign wb.data      = wb_q.data;
    assign wb.last      = wb_q.last;

`ifdef TT_LOAD_DRAIN_PERF_EN
    logic wait_stall;
    logic bp_stall;

    assign wait_stall = (state == WAIT) && !data_rdy;
    assign bp_stall   = (state == WB) && !wb.ready;

    tt_sat_counter #(.W(32)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_stall),
        .count (o_perf_wait_cycles)
    );

    tt_sat_counter #(.W(32)) u_bp_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bp_stall),
        .count (o_perf_bp_cycles)
    );
`else
    assign o_perf_wait_cycles = '0;
    assign o_perf_bp_cycles   = '0;
`endif

endmodule

// File: tb/tb_tt_load_drain_seq.sv
// Bench for tt_load_drain_seq: beat-queue model plus directed scenarios.
// Perf expectations follow TT_LOAD_DRAIN_PERF_EN.
module tb_tt_load_drain_seq;
    import tt_vpu_lq_pkg::*;

    typedef struct {
        int                lqid;
        logic [DATA_W-1:0] data;
        bit                last;
    } beat_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                i_drain_req = 1'b0;
    logic [LQID_W-1:0]   i_drain_ref_count = '0;
    logic [LQID_W-1:0]   i_drain_lqid_start = '0;
    logic                o_draining;
    logic [LQ_DEPTH-1:0] i_lq_data_valid = '0;
    logic [LQID_W-1:0]   o_lq_rd_lqid;
    logic [DATA_W-1:0]   i_lq_rd_data;
    logic                o_lq_commit;
    logic [LQID_W-1:0]   o_dest_lqid;
    logic [31:0]         o_perf_wait_cycles;
    logic [31:0]         o_perf_bp_cycles;

    tt_load_drain_seq_if wb();

    logic [DATA_W-1:0] mem [LQ_DEPTH];
    assign i_lq_rd_data = mem[o_lq_rd_lqid];

    always #5 clk = ~clk;

    tt_load_drain_seq dut (
        .clk                (clk),
        .reset              (reset),
        .i_drain_req        (i_drain_req),
        .i_drain_ref_count  (i_drain_ref_count),
        .i_drain_lqid_start (i_drain_lqid_start),
        .o_draining         (o_draining),
        .i_lq_data_valid    (i_lq_data_valid),
        .o_lq_rd_lqid       (o_lq_rd_lqid),
        .i_lq_rd_data       (i_lq_rd_data),
        .wb                 (wb),
        .o_lq_commit        (o_lq_commit),
        .o_dest_lqid        (o_dest_lqid),
        .o_perf_wait_cycles (o_perf_wait_cycles),
        .o_perf_bp_cycles   (o_perf_bp_cycles)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, logic [DATA_W-1:0] act,
                       logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a drain is a list of beats; busy until its last handshake.
    beat_t             exp_q[$];
    bit                m_busy = 0;
    bit                m_commit = 0;
    bit                m_rst_seen = 0;
    int                m_dest = 0;
    bit                prev_valid = 0;
    bit                prev_stall = 0;
    bit                prev_hs = 0;
    logic [LQ_DEPTH-1:0] prev_flags = '0;
    logic [LQID_W-1:0] prev_lqid = '0;
    logic [DATA_W-1:0] prev_data = '0;
    bit                prev_last = 0;

    int hs_q[$];
    int commit_q[$];
    int last_q[$];
    int drain_cycles = 0;
    int acc_cnt = 0;
    bit saw_valid = 0;
    bit acc_with_commit = 0;

    always @(negedge clk) begin : mon
        bit    hs;
        bit    was_busy;
        int    n;
        beat_t b;
        if (m_rst_seen) begin
            chk("rst_wb_valid", wb.valid, 0);
            chk("rst_wb_lqid", wb.lqid, 0);
            chk("rst_wb_data", wb.data, 0);
            chk("rst_wb_last", wb.last, 0);
            chk("rst_rd_lqid", o_lq_rd_lqid, 0);
            chk("rst_dest", o_dest_lqid, 0);
            chk("rst_perf_wait", o_perf_wait_cycles, 0);
            chk("rst_perf_bp", o_perf_bp_cycles, 0);
        end
        chk("draining", o_draining, m_busy);
        chk("commit", o_lq_commit, m_commit);
        if (m_commit) chk("dest_lqid", o_dest_lqid, m_dest);
        if (prev_hs) chk("wait_gap", wb.valid, 0);
        if (prev_stall) begin
            chk("hold_valid", wb.valid, 1);
            chk("hold_lqid", wb.lqid, prev_lqid);
            chk("hold_data", wb.data, prev_data);
            chk("hold_last", wb.last, prev_last);
        end
        if (wb.valid) begin
            chk("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                chk("wb_lqid", wb.lqid, exp_q[0].lqid);
                chk("wb_data", wb.data, exp_q[0].data);
                chk("wb_last", wb.last, exp_q[0].last);
            end
            if (!prev_valid) chk("data_flag", prev_flags[wb.lqid], 1);
        end

        hs = wb.valid && wb.ready;
        if (o_draining) drain_cycles++;
        if (o_lq_commit) commit_q.push_back(int'(o_dest_lqid));
        if (wb.valid) saw_valid = 1;
        if (hs) hs_q.push_back(int'(wb.lqid));
        if (hs && wb.last) last_q.push_back(int'(wb.lqid));

        if (reset) begin
            exp_q.delete();
            m_busy = 0;
            m_commit = 0;
            m_rst_seen = 1;
            prev_valid = 0;
            prev_stall = 0;
            prev_hs = 0;
        end else begin
            m_rst_seen = 0;
            was_busy = m_busy;
            m_commit = hs && (exp_q.size() > 0);
            m_dest = int'(wb.lqid);
            if (m_commit) begin
                if (exp_q[0].last) m_busy = 0;
                void'(exp_q.pop_front());
            end
            if (!was_busy && i_drain_req) begin
                n = (i_drain_ref_count == 0) ? LQ_DEPTH
                                             : int'(i_drain_ref_count);
                for (int i = 0; i < n; i++) begin
                    b.lqid = (int'(i_drain_lqid_start) + i) % LQ_DEPTH;
                    b.data = mem[b.lqid];
                    b.last = (i == n - 1);
                    exp_q.push_back(b);
                end
                m_busy = 1;
                acc_cnt++;
                acc_with_commit = o_lq_commit;
            end
            prev_valid = wb.valid;
            prev_stall = wb.valid && !wb.ready;
            prev_hs = hs;
        end
        prev_flags = i_lq_data_valid;
        prev_lqid = wb.lqid;
        prev_data = wb.data;
        prev_last = wb.last;
    end

    function automatic int packq(int q[$]);
        int a = 0;
        foreach (q[i]) a = (a << 3) | q[i];
        return a;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hs_q.delete();
        commit_q.delete();
        last_q.delete();
        drain_cycles = 0;
        saw_valid = 0;
    endtask

    task automatic start_drain(int s, int c);
        i_drain_lqid_start = LQID_W'(s);
        i_drain_ref_count = LQID_W'(c);
        i_drain_req = 1'b1;
        cyc();
        i_drain_req = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int k = 0;
        while (o_draining && k < budget) begin
            cyc();
            k++;
        end
        chk("idle_timeout", o_draining, 0);
    endtask

    task automatic wait_valid(int budget);
        int k = 0;
        while (!wb.valid && k < budget) begin
            cyc();
            k++;
        end
        chk("valid_timeout", wb.valid, 1);
    endtask

    initial begin
        logic [31:0] p0;
        int base;
        for (int i = 0; i < LQ_DEPTH; i++)
            for (int j = 0; j < DATA_W / 32; j++)
                mem[i][j*32 +: 32] = $urandom;
        wb.ready = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        // basic drain
        i_lq_data_valid = '1;
        clr();
        start_drain(2, 3);
        wait_idle(50);
        cyc();
        cyc();
        chk("t1_hs_lqids", packq(hs_q), {3'd2, 3'd3, 3'd4});
        chk("t1_hs_count", hs_q.size(), 3);
        chk("t1_commits", packq(commit_q), {3'd2, 3'd3, 3'd4});
        chk("t1_commit_count", commit_q.size(), 3);
        chk("t1_last", packq(last_q), 4);
        chk("t1_drain_cycles", drain_cycles, 6);

        // wrap with count 0
        clr();
        start_drain(6, 0);
        wait_idle(60);
        cyc();
        cyc();
        chk("t2_hs_lqids", packq(hs_q),
            {3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5});
        chk("t2_hs_count", hs_q.size(), 8);
        chk("t2_last_count", last_q.size(), 1);
        chk("t2_last", packq(last_q), 5);

        // data stall on entry 1
        clr();
        i_lq_data_valid = 8'hFD;
        p0 = o_perf_wait_cycles;
        start_drain(1, 2);
        repeat (5) cyc();
        chk("t3_no_early_valid", saw_valid, 0);
        i_lq_data_valid = '1;
        wait_idle(50);
        cyc();
        cyc();
        chk("t3_hs_lqids", packq(hs_q), {3'd1, 3'd2});
`ifdef TT_LOAD_DRAIN_PERF_EN
        chk("t3_perf_wait", o_perf_wait_cycles - p0, 5);
`else
        chk("t3_perf_wait", o_perf_wait_cycles, 0);
`endif

        // backpressure on first beat
        clr();
        wb.ready = 1'b0;
        p0 = o_perf_bp_cycles;
        start_drain(3, 2);
        wait_valid(20);
        repeat (3) cyc();
        wb.ready = 1'b1;
        wait_idle(50);
        cyc();
        cyc();
        chk("t4_hs_lqids", packq(hs_q), {3'd3, 3'd4});
        chk("t4_commits", packq(commit_q), {3'd3, 3'd4});
        chk("t4_commit_count", commit_q.size(), 2);
`ifdef TT_LOAD_DRAIN_PERF_EN
        chk("t4_perf_bp", o_perf_bp_cycles - p0, 3);
`else
        chk("t4_perf_bp", o_perf_bp_cycles, 0);
`endif

        // request held high across a drain
        clr();
        base = acc_cnt;
        i_drain_lqid_start = 3'd0;
        i_drain_ref_count = 3'd2;
        i_drain_req = 1'b1;
        cyc();
        i_drain_lqid_start = 3'd4;
        i_drain_ref_count = 3'd1;
        for (int k = 0; k < 30 && acc_cnt < base + 2; k++) cyc();
        i_drain_req = 1'b0;
        chk("t5_accepts", acc_cnt - base, 2);
        chk("t5_accept_on_commit", acc_with_commit, 1);
        wait_idle(50);
        cyc();
        cyc();
        chk("t5_hs_lqids", packq(hs_q), {3'd0, 3'd1, 3'd4});
        chk("t5_last", packq(last_q), {3'd1, 3'd4});

        // reset while a beat is pending
        clr();
        wb.ready = 1'b0;
        start_drain(5, 3);
        wait_valid(20);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_draining", o_draining, 0);
        chk("t6_wb_valid", wb.valid, 0);
        chk("t6_commit", o_lq_commit, 0);
        cyc();
        cyc();
        chk("t6_no_commit", commit_q.size(), 0);
        chk("t6_no_hs", hs_q.size(), 0);
        wb.ready = 1'b1;
        start_drain(7, 2);
        wait_idle(50);
        cyc();
        cyc();
        chk("t6_hs_lqids", packq(hs_q), {3'd7, 3'd0});
        chk("t6_commits", packq(commit_q), {3'd7, 3'd0});

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            i_lq_data_valid = LQ_DEPTH'($urandom);
            wb.ready = ($urandom_range(0, 3) != 0);
            i_drain_req = ($urandom_range(0, 2) == 0);
            i_drain_lqid_start = LQID_W'($urandom);
            i_drain_ref_count = LQID_W'($urandom);
            reset = ($urandom_range(0, 599) == 0);
            cyc();
        end
        reset = 1'b0;
        i_drain_req = 1'b0;
        i_lq_data_valid = '1;
        wb.ready = 1'b1;
        wait_idle(100);
        cyc();
        cyc();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
